sync_fifo_lvl: RTL and testbench
================================

// Module: sync_fifo_lvl
// PURPOSE
//   Parametrised single-clock FIFO: any depth >= 2, not only powers of two. Provides fill level, programmable
//   almost-full/almost-empty flags and a registered read port with a valid strobe.
//   Buffers data between blocks that share one clock domain (e.g. register file <-> UART TX/ALU result queue).
//   Successor of the dual-clock FIFO for same-domain use: no pointer synchronisers, exact occupancy count.
// PARAMETERS
//   DATA_WIDTH  8  width of one data word
//   DEPTH       8  number of storage words, >= 2, any integer
//   AFULL_TH    6  O_AFULL asserted when count >= AFULL_TH, range 1..DEPTH
//   AEMPTY_TH   2  O_AEMPTY asserted when count <= AEMPTY_TH, range 0..DEPTH-1
// PORTS
//   I_CLK      in   1                 clock; all logic on rising edge
//   I_RST      in   1                 asynchronous, active-low reset
//   I_WR_EN    in   1                 push request
//   I_WR_DATA  in   DATA_WIDTH        push data
//   I_RD_EN    in   1                 pop request
//   O_RD_DATA  out  DATA_WIDTH        popped word, registered
//   O_RD_VALID out  1                 O_RD_DATA valid for this cycle (one-cycle pulse per pop)
//   O_FULL     out  1                 count == DEPTH
//   O_EMPTY    out  1                 count == 0
//   O_AFULL    out  1                 count >= AFULL_TH
//   O_AEMPTY   out  1                 count <= AEMPTY_TH
//   O_COUNT    out  CNT_W             occupancy, 0..DEPTH; CNT_W = clog2(DEPTH+1)
//   O_OVF      out  1                 (SYNC_FIFO_LVL_ERR_EN only) sticky overflow
//   O_UDF      out  1                 (SYNC_FIFO_LVL_ERR_EN only) sticky underflow
//   I_CLR_ERR  in   1                 (SYNC_FIFO_LVL_ERR_EN only) synchronous clear of O_OVF/O_UDF
// BEHAVIOUR
//   Reset (I_RST=0, async): wr_ptr=rd_ptr=0, O_COUNT=0, O_EMPTY=1, O_FULL=0, O_AEMPTY=1, O_AFULL=0,
//     O_RD_DATA=0, O_RD_VALID=0, O_OVF=O_UDF=0. Storage array is not cleared. Reset mid-burst discards all content.
//   pop_ok  = I_RD_EN & ~O_EMPTY.
//   push_ok = I_WR_EN & (~O_FULL | pop_ok). Push while full is accepted only together with a pop.
//     Read-before-write at the shared slot: the pop returns the old word.
//   Push while empty with a simultaneous pop: push accepted, pop rejected. No bypass; the word is readable next cycle.
//   Pointers: ADDR_W = clog2(DEPTH); increment on accept; DEPTH-1 wraps to 0 (explicit compare, not modulo-2^n).
//   Count: +1 on push_ok only, -1 on pop_ok only, unchanged on both or neither. Never exceeds DEPTH or drops below 0.
//   Flags: registered, computed from next-count, so flags and O_COUNT change on the same edge as the accepting edge.
//   Read latency: 1 cycle. pop_ok at edge N -> O_RD_DATA = mem[rd_ptr] and O_RD_VALID=1 after edge N.
//     Without a pop, O_RD_VALID=0 and O_RD_DATA holds its last value.
//   Rejected requests (push when full with no pop, pop when empty) do not change pointers, count or memory.
// CONFIGURATION
//   `SYNC_FIFO_LVL_ERR_EN defined: ports O_OVF, O_UDF, I_CLR_ERR exist.
//     O_OVF sets on I_WR_EN & ~push_ok; O_UDF sets on I_RD_EN & O_EMPTY.
//     Both are sticky until I_CLR_ERR=1. A set and a clear in the same cycle -> set wins.
//   Not defined: these ports and their registers are absent; rejected requests are silently dropped.
// STRUCTURE
//   Package fifo_pkg: function clog2, localparams ADDR_W / CNT_W derivation helpers, ptr_next() wrap function.
//   Sub-module fifo_lvl_ram: DEPTH x DATA_WIDTH array, one write port (we, waddr, wdata),
//     one registered read port (re, raddr, rdata). Pointer, count and flag logic stays in sync_fifo_lvl.
// TESTING  (DATA_WIDTH=8, DEPTH=6, AFULL_TH=5, AEMPTY_TH=1)
//   Reset: hold I_RST=0 with random I_WR_EN/I_RD_EN -> O_COUNT=0, O_EMPTY=1, O_AEMPTY=1, O_RD_VALID=0 throughout.
//   Fill: push 0x10..0x15 -> O_AFULL rises after the 5th push, O_FULL and O_COUNT=6 after the 6th.
//     A 7th push is rejected; O_COUNT stays 6.
//   Drain: pop 6x -> O_RD_DATA 0x10..0x15, each one cycle after its pop; O_AEMPTY at count 1; O_EMPTY after the 6th.
//   Wrap: 20 cycles of push+pop at count 3, non-power-of-two depth -> data order preserved, O_COUNT constant at 3.
//   Boundaries: push+pop while full -> old head returned, count stays 6.
//     Push+pop while empty -> count becomes 1, O_RD_VALID=0.
//   Errors (macro on): push at full without pop -> O_OVF=1; pop at empty -> O_UDF=1;
//     I_CLR_ERR -> both 0; set and clear in the same cycle -> flag stays 1.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared helpers for the single-clock level FIFO: width derivation, pointer wrap,
// the push/pop operation encoding and the registered status-flag bundle.
package fifo_pkg;

    // Number of bits needed to index `value` distinct items (0 for value <= 1).
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned v;
        int unsigned r;
        r = 0;
        v = (value > 0) ? value - 1 : 0;
        while (v > 0) begin
            r++;
            v = v >> 1;
        end
        return r;
    endfunction

    function automatic int unsigned addr_width(input int unsigned depth);
        return (clog2(depth) < 1) ? 1 : clog2(depth);
    endfunction

    // The count must represent 0..depth inclusive.
    function automatic int unsigned cnt_width(input int unsigned depth);
        return clog2(depth + 1);
    endfunction

    // Explicit wrap at depth-1 so that non-power-of-two depths use every slot.
    function automatic int unsigned ptr_next(input int unsigned ptr, input int unsigned depth);
        return (ptr == depth - 1) ? 0 : ptr + 1;
    endfunction

    typedef enum logic [1:0] {
        OP_IDLE = 2'b00,
        OP_POP  = 2'b01,
        OP_PUSH = 2'b10,
        OP_BOTH = 2'b11
    } fifo_op_e;

    typedef struct packed {
        logic full;
        logic empty;
        logic afull;
        logic aempty;
    } fifo_flags_t;

    // Flag values for an empty FIFO; thresholds guarantee afull=0 and aempty=1 at count 0.
    localparam fifo_flags_t FLAGS_RESET = '{full: 1'b0, empty: 1'b1, afull: 1'b0, aempty: 1'b1};

endpackage

// File: rtl/fifo_lvl_ram.sv
// DEPTH x DATA_WIDTH storage with one write port and one registered read port.
// A read and a write to the same slot on one edge return the old word.
module fifo_lvl_ram #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned DEPTH      = 8,
    parameter int unsigned ADDR_W     = 3
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  we_i,
    input  logic [ADDR_W-1:0]     waddr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic                  re_i,
    input  logic [ADDR_W-1:0]     raddr_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] rdata_q;

    // NOTE: the array has no reset; clearing it would turn the RAM into a flop bank,
    // and the pointers already make stale contents unreachable.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem[waddr_i] <= wdata_i;
        end
    end

    // The read register holds its value between pops and is zero after reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/sync_fifo_lvl.sv
// Single-clock FIFO of any depth >= 2 with exact fill level, programmable almost flags
// and a registered read port. Define SYNC_FIFO_LVL_ERR_EN for sticky overflow/underflow flags.
module sync_fifo_lvl
    import fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned DEPTH      = 8,
    parameter int unsigned AFULL_TH   = 6,
    parameter int unsigned AEMPTY_TH  = 2,
    localparam int unsigned CNT_W     = cnt_width(DEPTH)
) (
    input  logic                  I_CLK,
    input  logic                  I_RST,
    input  logic                  I_WR_EN,
    input  logic [DATA_WIDTH-1:0] I_WR_DATA,
    input  logic                  I_RD_EN,
    output logic [DATA_WIDTH-1:0] O_RD_DATA,
    output logic                  O_RD_VALID,
    output logic                  O_FULL,
    output logic                  O_EMPTY,
    output logic                  O_AFULL,
    output logic                  O_AEMPTY,
    output logic [CNT_W-1:0]      O_COUNT
`ifdef SYNC_FIFO_LVL_ERR_EN
    ,
    input  logic                  I_CLR_ERR,
    output logic                  O_OVF,
    output logic                  O_UDF
`endif
);

    localparam int unsigned       ADDR_W     = addr_width(DEPTH);
    localparam logic [CNT_W-1:0]  DEPTH_CNT  = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0]  AFULL_CNT  = CNT_W'(AFULL_TH);
    localparam logic [CNT_W-1:0]  AEMPTY_CNT = CNT_W'(AEMPTY_TH);

    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    fifo_flags_t       flags_q, flags_d;
    logic              rd_valid_q;
    logic              push_ok, pop_ok;
    fifo_op_e          op;

    // A full FIFO still takes a word when the same cycle frees one; an empty one never bypasses.
    assign pop_ok  = I_RD_EN & ~flags_q.empty;
    assign push_ok = I_WR_EN & (~flags_q.full | pop_ok);
    assign op      = fifo_op_e'({push_ok, pop_ok});

    // NOTE: every always_comb output gets its default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        if (push_ok) begin
            wr_ptr_d = ADDR_W'(ptr_next(32'(wr_ptr_q), DEPTH));
        end
        if (pop_ok) begin
            rd_ptr_d = ADDR_W'(ptr_next(32'(rd_ptr_q), DEPTH));
        end

        unique case (op)
            OP_PUSH: count_d = count_q + 1'b1;
            OP_POP:  count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Flags come from the next count so they move on the same edge as O_COUNT.
    always_comb begin
        flags_d        = FLAGS_RESET;
        flags_d.full   = (count_d == DEPTH_CNT);
        flags_d.empty  = (count_d == '0);
        flags_d.afull  = (count_d >= AFULL_CNT);
        flags_d.aempty = (count_d <= AEMPTY_CNT);
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge I_CLK or negedge I_RST) begin
        if (!I_RST) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            flags_q    <= FLAGS_RESET;
            rd_valid_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            flags_q    <= flags_d;
            rd_valid_q <= pop_ok;
        end
    end

    fifo_lvl_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .ADDR_W     (ADDR_W)
    ) u_ram (
        .clk_i   (I_CLK),
        .rst_ni  (I_RST),
        .we_i    (push_ok),
        .waddr_i (wr_ptr_q),
        .wdata_i (I_WR_DATA),
        .re_i    (pop_ok),
        .raddr_i (rd_ptr_q),
        .rdata_o (O_RD_DATA)
    );

    assign O_RD_VALID = rd_valid_q;
    assign O_FULL     = flags_q.full;
    assign O_EMPTY    = flags_q.empty;
    assign O_AFULL    = flags_q.afull;
    assign O_AEMPTY   = flags_q.aempty;
    assign O_COUNT    = count_q;

`ifdef SYNC_FIFO_LVL_ERR_EN
    logic ovf_q, udf_q;
    logic ovf_set, udf_set;

    assign ovf_set = I_WR_EN & ~push_ok;
    assign udf_set = I_RD_EN & flags_q.empty;

    // A new error in the clearing cycle must not be lost, so set has priority.
    always_ff @(posedge I_CLK or negedge I_RST) begin
        if (!I_RST) begin
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
        end else begin
            if (ovf_set) begin
                ovf_q <= 1'b1;
            end else if (I_CLR_ERR) begin
                ovf_q <= 1'b0;
            end
            if (udf_set) begin
                udf_q <= 1'b1;
            end else if (I_CLR_ERR) begin
                udf_q <= 1'b0;
            end
        end
    end

    assign O_OVF = ovf_q;
    assign O_UDF = udf_q;
`endif

endmodule

// File: tb/tb_sync_fifo_lvl.sv
// Self-checking bench for sync_fifo_lvl (DEPTH=6) against a queue-based reference model.
// Error-flag checks are active when SYNC_FIFO_LVL_ERR_EN is defined.
module tb_sync_fifo_lvl;

    localparam int unsigned DW    = 8;
    localparam int unsigned DEPTH = 6;
    localparam int unsigned AF    = 5;
    localparam int unsigned AE    = 1;
    localparam int unsigned CW    = 3;

    logic          I_CLK = 1'b0;
    logic          I_RST = 1'b0;
    logic          I_WR_EN = 1'b0;
    logic [DW-1:0] I_WR_DATA = '0;
    logic          I_RD_EN = 1'b0;
    logic          I_CLR_ERR = 1'b0;
    logic [DW-1:0] O_RD_DATA;
    logic          O_RD_VALID, O_FULL, O_EMPTY, O_AFULL, O_AEMPTY;
    logic [CW-1:0] O_COUNT;
`ifdef SYNC_FIFO_LVL_ERR_EN
    logic          O_OVF, O_UDF;
`endif

    int unsigned passed = 0;
    int unsigned total  = 0;

    logic [DW-1:0] model_q[$];
    logic [DW-1:0] m_rd_data = '0;
    logic          m_valid = 1'b0;
    logic          m_ovf = 1'b0;
    logic          m_udf = 1'b0;

    sync_fifo_lvl #(
        .DATA_WIDTH (DW),
        .DEPTH      (DEPTH),
        .AFULL_TH   (AF),
        .AEMPTY_TH  (AE)
    ) dut (
        .I_CLK      (I_CLK),
        .I_RST      (I_RST),
        .I_WR_EN    (I_WR_EN),
        .I_WR_DATA  (I_WR_DATA),
        .I_RD_EN    (I_RD_EN),
        .O_RD_DATA  (O_RD_DATA),
        .O_RD_VALID (O_RD_VALID),
        .O_FULL     (O_FULL),
        .O_EMPTY    (O_EMPTY),
        .O_AFULL    (O_AFULL),
        .O_AEMPTY   (O_AEMPTY),
        .O_COUNT    (O_COUNT)
`ifdef SYNC_FIFO_LVL_ERR_EN
        ,
        .I_CLR_ERR  (I_CLR_ERR),
        .O_OVF      (O_OVF),
        .O_UDF      (O_UDF)
`endif
    );

    always #5 I_CLK = ~I_CLK;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic check_all(input string tag);
        int sz;
        sz = model_q.size();
        check({tag, ":count"},  32'(O_COUNT),    32'(sz));
        check({tag, ":empty"},  32'(O_EMPTY),    32'(sz == 0));
        check({tag, ":full"},   32'(O_FULL),     32'(sz == DEPTH));
        check({tag, ":afull"},  32'(O_AFULL),    32'(sz >= AF));
        check({tag, ":aempty"}, 32'(O_AEMPTY),   32'(sz <= AE));
        check({tag, ":valid"},  32'(O_RD_VALID), 32'(m_valid));
        check({tag, ":data"},   32'(O_RD_DATA),  32'(m_rd_data));
`ifdef SYNC_FIFO_LVL_ERR_EN
        check({tag, ":ovf"},    32'(O_OVF),      32'(m_ovf));
        check({tag, ":udf"},    32'(O_UDF),      32'(m_udf));
`endif
    endtask

    // One clock with the given request; the model applies the same request to its queue.
    task automatic step(input string tag, input logic wr, input logic [DW-1:0] d,
                        input logic rd, input logic clr);
        logic can_pop, can_push;
        I_WR_EN   = wr;
        I_WR_DATA = d;
        I_RD_EN   = rd;
        I_CLR_ERR = clr;
        @(posedge I_CLK);
        #1;
        can_pop  = rd && (model_q.size() != 0);
        can_push = wr && ((model_q.size() < DEPTH) || can_pop);
        if (wr && !can_push) m_ovf = 1'b1;
        else if (clr)        m_ovf = 1'b0;
        if (rd && model_q.size() == 0) m_udf = 1'b1;
        else if (clr)                  m_udf = 1'b0;
        m_valid = can_pop;
        if (can_pop) m_rd_data = model_q.pop_front();
        if (can_push) model_q.push_back(d);
        check_all(tag);
    endtask

    task automatic model_reset();
        model_q.delete();
        m_rd_data = '0;
        m_valid   = 1'b0;
        m_ovf     = 1'b0;
        m_udf     = 1'b0;
    endtask

    initial begin
        // Reset held with random requests: nothing may be accepted.
        I_RST = 1'b0;
        for (int i = 0; i < 6; i++) begin
            I_WR_EN   = 1'($urandom);
            I_RD_EN   = 1'($urandom);
            I_WR_DATA = DW'($urandom);
            I_CLR_ERR = 1'($urandom);
            @(posedge I_CLK);
            #1;
            check("rst:count",  32'(O_COUNT),    32'd0);
            check("rst:empty",  32'(O_EMPTY),    32'd1);
            check("rst:aempty", 32'(O_AEMPTY),   32'd1);
            check("rst:valid",  32'(O_RD_VALID), 32'd0);
        end
        check("rst:full",  32'(O_FULL),    32'd0);
        check("rst:afull", 32'(O_AFULL),   32'd0);
        check("rst:data",  32'(O_RD_DATA), 32'd0);
        model_reset();
        I_RST = 1'b1;

        // Fill 0x10..0x15, then one rejected push.
        for (int i = 0; i < 6; i++) step("fill", 1'b1, DW'(8'h10 + i), 1'b0, 1'b0);
        step("fill7", 1'b1, 8'hEE, 1'b0, 1'b0);
        check("fill7:count", 32'(O_COUNT), 32'd6);

        // Push+pop while full returns the old head and keeps count at 6.
        step("fullpp", 1'b1, 8'hA5, 1'b1, 1'b0);
        check("fullpp:head", 32'(O_RD_DATA), 32'h10);

        // Drain everything.
        for (int i = 0; i < 6; i++) step("drain", 1'b0, '0, 1'b1, 1'b0);
        check("drain:empty", 32'(O_EMPTY), 32'd1);

        // Pop at empty (underflow), then clear, then set+clear in one cycle.
        step("udf", 1'b0, '0, 1'b1, 1'b0);
        step("clr", 1'b0, '0, 1'b0, 1'b1);
        step("udfclr", 1'b0, '0, 1'b1, 1'b1);

        // Push+pop while empty: push accepted, pop rejected, no bypass.
        step("emptypp", 1'b1, 8'h3C, 1'b1, 1'b1);
        check("emptypp:count", 32'(O_COUNT), 32'd1);
        check("emptypp:valid", 32'(O_RD_VALID), 32'd0);

        // Overflow at full, then clear.
        for (int i = 0; i < 5; i++) step("refill", 1'b1, DW'($urandom), 1'b0, 1'b0);
        step("ovf", 1'b1, 8'h77, 1'b0, 1'b0);
        step("ovfclr", 1'b0, '0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) step("to3", 1'b0, '0, 1'b1, 1'b0);

        // Wrap: steady push+pop at count 3 walks the pointers around several times.
        for (int i = 0; i < 20; i++) step("wrap", 1'b1, DW'($urandom), 1'b1, 1'b0);
        check("wrap:count", 32'(O_COUNT), 32'd3);

        // Random traffic, first write-biased, then read-biased.
        for (int i = 0; i < 300; i++)
            step("rndw", ($urandom_range(0, 99) < 65), DW'($urandom),
                 ($urandom_range(0, 99) < 40), ($urandom_range(0, 99) < 10));
        for (int i = 0; i < 300; i++)
            step("rndr", ($urandom_range(0, 99) < 40), DW'($urandom),
                 ($urandom_range(0, 99) < 65), ($urandom_range(0, 99) < 10));

        // Asynchronous reset mid-burst discards content immediately.
        for (int i = 0; i < 4; i++) step("pre", 1'b1, DW'($urandom), 1'b0, 1'b0);
        #2;
        I_RST = 1'b0;
        #1;
        check("arst:count", 32'(O_COUNT),    32'd0);
        check("arst:empty", 32'(O_EMPTY),    32'd1);
        check("arst:valid", 32'(O_RD_VALID), 32'd0);
        check("arst:data",  32'(O_RD_DATA),  32'd0);
        model_reset();
        @(negedge I_CLK);
        I_RST = 1'b1;
        for (int i = 0; i < 40; i++)
            step("post", 1'(($urandom)), DW'($urandom), 1'($urandom), 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
